// File: rtl/key_collector_if.sv
// Bus between the group key queues / processor register path and the key collector.
// Signal names follow the existing group-block wiring (keyIn, Qempty, popQ, ...).
interface key_collector_if #(
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned CNT_W      = 16
);
  logic                     stop;
  logic [NUM_GROUPS*32-1:0] keyIn;
  logic [NUM_GROUPS-1:0]    Qempty;
  logic [NUM_GROUPS-1:0]    popQ;
  logic [31:0]              keyOut;
  logic                     keyValid;
  logic                     keyAck;
  logic [CNT_W-1:0]         keyCount;
  logic                     fifoFull;

  // Environment side: groups, stop source and the consumer.
  modport master (
    output stop, keyIn, Qempty, keyAck,
    input  popQ, keyOut, keyValid, keyCount, fifoFull
  );

  // Collector side.
  modport slave (
    input  stop, keyIn, Qempty, keyAck,
    output popQ, keyOut, keyValid, keyCount, fifoFull
  );
endinterface

// File: rtl/key_collector.sv
// Key collector: round-robin drains show-ahead group key queues into a local FIFO and
// presents keys to the processor with a valid/ack handshake. Counts collected keys.
module key_collector #(
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned DEPTH      = 8,   // power of 2, >= 2
  parameter int unsigned CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  key_collector_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned RrW  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [PtrW:0]  DepthL   = (PtrW+1)'(DEPTH);
  localparam logic [RrW-1:0] LastGrp  = RrW'(NUM_GROUPS - 1);

  logic [31:0]           mem_q [DEPTH];
  logic [PtrW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]         occ_q, occ_d;
  logic [RrW-1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RrW-1:0]        gnt_idx;
  logic                  gnt_vld;
  logic                  rd_en;
  logic [NUM_GROUPS-1:0] pop;
  logic [31:0]           wr_key;

  // Round-robin grant from rr; a same-cycle read never makes room for a write.
  always_comb begin
    int unsigned   g;
    logic [RrW-1:0] cand;
    g       = 0;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!rst && !bus.stop && (occ_q < DepthL)) begin
      for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
        g    = (int'(rr_q) + i) % NUM_GROUPS;
        cand = RrW'(g);
        if (!gnt_vld && !bus.Qempty[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    pop          = '0;
    pop[gnt_idx] = gnt_vld;
  end

  // Next-state for pointers, occupancy, rr and the saturating counter.
  always_comb begin
    wr_key = bus.keyIn[32*gnt_idx +: 32];
    rd_en  = bus.keyAck && (occ_q != '0);
    wr_d   = gnt_vld ? wr_q + 1'b1 : wr_q;
    rd_d   = rd_en ? rd_q + 1'b1 : rd_q;
    occ_d  = occ_q;
    unique case ({gnt_vld, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    rr_d = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_idx == LastGrp) ? '0 : gnt_idx + 1'b1;
    end
    cnt_d = cnt_q;
    if (gnt_vld && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; captures the granted group's head key on the pop edge.
  always_ff @(posedge clk) begin
    if (gnt_vld) begin
      mem_q[wr_q] <= wr_key;
    end
  end

  // Output drive.
  always_comb begin
    bus.popQ     = pop;
    bus.keyOut   = mem_q[rd_q];
    bus.keyValid = (occ_q != '0);
    bus.fifoFull = (occ_q == DepthL);
    bus.keyCount = cnt_q;
  end
endmodule

// File: tb/tb_key_collector.sv
// Randomized and directed bench for key_collector with a queue-based reference model and a
// scoreboard. A second instance with a 4-bit counter checks saturation on the same stimulus.
module tb_key_collector;
  localparam int NG    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              stop_r = 1'b0;
  logic              ack_r  = 1'b0;
  logic [NG*32-1:0]  key_in = '0;
  logic [NG-1:0]     qempty = '1;

  key_collector_if #(.NUM_GROUPS(NG), .CNT_W(16)) bus ();
  key_collector_if #(.NUM_GROUPS(NG), .CNT_W(4))  bus4 ();

  assign bus.stop    = stop_r;
  assign bus.keyAck  = ack_r;
  assign bus.keyIn   = key_in;
  assign bus.Qempty  = qempty;
  assign bus4.stop   = stop_r;
  assign bus4.keyAck = ack_r;
  assign bus4.keyIn  = key_in;
  assign bus4.Qempty = qempty;

  key_collector #(.NUM_GROUPS(NG), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  key_collector #(.NUM_GROUPS(NG), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Group queues (the bench plays the groups), scoreboard and reference state.
  bit [31:0]   gq [NG][$];
  bit [31:0]   sb [$];
  int          mocc, mrr, mcnt;
  int          gnt_g;
  logic [NG-1:0] exp_pop;
  bit          exp_valid, exp_full;
  int          exp_cnt;
  bit          chk_en = 1'b0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: present inputs, predict outputs, then advance the model past the edge.
  task automatic drive(input bit r, input bit s, input bit a);
    bit rd;
    rst    = r;
    stop_r = s;
    ack_r  = a;
    for (int g = 0; g < NG; g++) begin
      qempty[g]          = (gq[g].size() == 0);
      key_in[32*g +: 32] = (gq[g].size() != 0) ? gq[g][0] : $urandom();
    end
    gnt_g = -1;
    if (!r && !s && mocc < DEPTH) begin
      for (int i = 0; i < NG; i++) begin
        int g;
        g = (mrr + i) % NG;
        if (gnt_g < 0 && gq[g].size() > 0) gnt_g = g;
      end
    end
    exp_pop = '0;
    if (gnt_g >= 0) exp_pop[gnt_g] = 1'b1;
    exp_valid = (mocc != 0);
    exp_full  = (mocc == DEPTH);
    exp_cnt   = mcnt;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
    if (r) begin
      mocc = 0;
      mrr  = 0;
      mcnt = 0;
      sb.delete();
    end else begin
      rd = a && (mocc != 0);
      if (gnt_g >= 0) begin
        sb.push_back(gq[gnt_g].pop_front());
        mrr = (gnt_g + 1) % NG;
        mcnt++;
      end
      mocc = mocc + ((gnt_g >= 0) ? 1 : 0) - (rd ? 1 : 0);
    end
  endtask

  task automatic clear_groups();
    for (int g = 0; g < NG; g++) gq[g].delete();
  endtask

  task automatic refill(input bit pattern);
    for (int g = 0; g < NG; g++) begin
      if (gq[g].size() == 0) gq[g].push_back(pattern ? (32'h1000_0000 | g) : $urandom());
    end
  endtask

  // Monitor: mid-cycle check of outputs; on a handshake pop the scoreboard and compare.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("popQ", 64'(bus.popQ), 64'(exp_pop));
      chk("keyValid", 64'(bus.keyValid), 64'(exp_valid));
      chk("fifoFull", 64'(bus.fifoFull), 64'(exp_full));
      chk("keyCount", 64'(bus.keyCount), 64'((exp_cnt > 65535) ? 65535 : exp_cnt));
      chk("keyCount4", 64'(bus4.keyCount), 64'((exp_cnt > 15) ? 15 : exp_cnt));
      if (bus.keyValid === 1'b1 && ack_r) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL keyOut @%0t: got %0h expected no key", $time, bus.keyOut);
        end else begin
          chk("keyOut", 64'(bus.keyOut), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    mocc = 0;
    mrr  = 0;
    mcnt = 0;
    @(posedge clk);
    #1;

    // Reset with every group non-empty: nothing may be popped.
    refill(1'b0);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    clear_groups();
    drive(1'b0, 1'b0, 1'b0);

    // Single key from group 2.
    gq[2].push_back(32'hDEAD_BEEF);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Round robin with continuous keys and continuous ack; start from a clean rr.
    drive(1'b1, 1'b0, 1'b0);
    repeat (16) begin
      refill(1'b1);
      drive(1'b0, 1'b0, 1'b1);
    end
    clear_groups();
    repeat (DEPTH + 2) drive(1'b0, 1'b0, 1'b1);

    // Fill to full, one ack cycle, refill to full, then drain.
    repeat (12) begin
      refill(1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    refill(1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (3) begin
      refill(1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    clear_groups();
    repeat (DEPTH + 2) drive(1'b0, 1'b0, 1'b1);

    // Stop with three keys buffered and groups non-empty.
    repeat (3) gq[1].push_back($urandom());
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    repeat (4) begin
      refill(1'b1);
      drive(1'b0, 1'b1, 1'b1);
    end
    repeat (6) begin
      refill(1'b1);
      drive(1'b0, 1'b0, 1'b1);
    end
    clear_groups();
    repeat (DEPTH + 2) drive(1'b0, 1'b0, 1'b1);

    // Random traffic including occasional stop and reset.
    repeat (400) begin
      bit r, s, a;
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(9) < 3) gq[g].push_back($urandom());
      end
      r = ($urandom_range(49) == 0);
      s = ($urandom_range(7) == 0);
      a = ($urandom_range(9) < 6);
      drive(r, s, a);
    end

    // Drain, then ack with the FIFO empty: count and pointers must hold.
    clear_groups();
    repeat (DEPTH + 6) drive(1'b0, 1'b0, 1'b1);

    @(posedge clk);
    chk_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
